// File: rtl/rst_seq_ctrl_pkg.sv
// rst_seq_ctrl_pkg
// Shared definitions for the reset sequencer: FSM state encodings and the
// reset-cause codes reported in the status register.
package rst_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        BUS_REL = 2'd1,
        RUN     = 2'd2
    } rst_state_e;

    localparam logic [1:0] RST_CAUSE_POR = 2'd0;
    localparam logic [1:0] RST_CAUSE_SW  = 2'd1;
    localparam logic [1:0] RST_CAUSE_WDT = 2'd2;

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// rst_seq_ctrl_if
// Request/status bundle of the reset sequencer.
//   sw_rst_req    : software reset request pulse        (master -> slave)
//   wdt_rst_req   : watchdog reset request, level/pulse  (master -> slave)
//   rst_cause_clr : clear the recorded reset cause       (master -> slave)
//   dbg_core_hold : hold core in reset, only when RST_SEQ_DBG_HOLD_EN is defined
//   bus_rst_n     : active-low bus/peripheral reset      (slave -> master)
//   core_rst_n    : active-low core reset                (slave -> master)
//   rst_busy      : sequence not yet in RUN              (slave -> master)
//   rst_cause     : cause of the last reset              (slave -> master)
// The sequencer itself connects through the slave modport.
interface rst_seq_ctrl_if;
    logic       sw_rst_req;
    logic       wdt_rst_req;
    logic       rst_cause_clr;
`ifdef RST_SEQ_DBG_HOLD_EN
    logic       dbg_core_hold;
`endif
    logic       bus_rst_n;
    logic       core_rst_n;
    logic       rst_busy;
    logic [1:0] rst_cause;

`ifdef RST_SEQ_DBG_HOLD_EN
    modport master (output sw_rst_req, wdt_rst_req, rst_cause_clr, dbg_core_hold,
                    input  bus_rst_n, core_rst_n, rst_busy, rst_cause);
    modport slave  (input  sw_rst_req, wdt_rst_req, rst_cause_clr, dbg_core_hold,
                    output bus_rst_n, core_rst_n, rst_busy, rst_cause);
`else
    modport master (output sw_rst_req, wdt_rst_req, rst_cause_clr,
                    input  bus_rst_n, core_rst_n, rst_busy, rst_cause);
    modport slave  (input  sw_rst_req, wdt_rst_req, rst_cause_clr,
                    output bus_rst_n, core_rst_n, rst_busy, rst_cause);
`endif
endinterface

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl
// SoC reset generator/sequencer. Stretches power-on, software and watchdog
// resets to HOLD_CYCLES, releases the bus domain first and the core domain
// STAGE_GAP cycles later, and records the cause of the last reset.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low power-on/system reset
//   sif   : rst_seq_ctrl_if.slave (requests, cause clear, reset outputs, status)
// Optional feature: RST_SEQ_DBG_HOLD_EN adds dbg_core_hold, which keeps the
// core in reset at the end of BUS_REL until it drops.
// All outputs come straight from flops.
module rst_seq_ctrl
    import rst_seq_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGE_GAP   = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    rst_seq_ctrl_if.slave  sif
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

    rst_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_q, bus_d;
    logic             core_q, core_d;
    logic             busy_q, busy_d;
    logic [1:0]       cause_q, cause_d;
    logic             req;
    logic             core_hold;

    assign req = sif.sw_rst_req | sif.wdt_rst_req;

`ifdef RST_SEQ_DBG_HOLD_EN
    assign core_hold = sif.dbg_core_hold;
`else
    assign core_hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            bus_q   <= 1'b0;
            core_q  <= 1'b0;
            busy_q  <= 1'b1;
            cause_q <= RST_CAUSE_POR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bus_q   <= bus_d;
            core_q  <= core_d;
            busy_q  <= busy_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bus_d   = bus_q;
        core_d  = core_q;
        busy_d  = busy_q;
        cause_d = cause_q;

        if (req) begin
            // Any request restarts the whole sequence; watchdog wins the cause.
            state_d = HOLD;
            cnt_d   = '0;
            bus_d   = 1'b0;
            core_d  = 1'b0;
            busy_d  = 1'b1;
            cause_d = sif.wdt_rst_req ? RST_CAUSE_WDT : RST_CAUSE_SW;
        end else begin
            if (sif.rst_cause_clr) begin
                cause_d = RST_CAUSE_POR;
            end
            case (state_q)
                HOLD: begin
                    bus_d  = 1'b0;
                    core_d = 1'b0;
                    busy_d = 1'b1;
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d   = '0;
                        bus_d   = 1'b1;
                        state_d = BUS_REL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                BUS_REL: begin
                    bus_d  = 1'b1;
                    core_d = 1'b0;
                    busy_d = 1'b1;
                    if (cnt_q == GAP_LAST) begin
                        // Debug hold parks the counter at its terminal value.
                        if (!core_hold) begin
                            cnt_d   = '0;
                            core_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = RUN;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    bus_d  = 1'b1;
                    core_d = 1'b1;
                    busy_d = 1'b0;
                end
                default: begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    bus_d   = 1'b0;
                    core_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            endcase
        end
    end

    assign sif.bus_rst_n  = bus_q;
    assign sif.core_rst_n = core_q;
    assign sif.rst_busy   = busy_q;
    assign sif.rst_cause  = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl
// Self-checking bench for rst_seq_ctrl. The reference model works in terms of
// elapsed clock edges since the last reset origin (rst_n release or last
// request edge): bus is released after HOLD edges, core after HOLD+GAP edges
// (and, with RST_SEQ_DBG_HOLD_EN, only once dbg_core_hold is seen low there).
module tb_rst_seq_ctrl;

    localparam int H = 16;
    localparam int G = 4;

    logic clk;
    logic rst_n;

    rst_seq_ctrl_if sif();

    rst_seq_ctrl #(
        .HOLD_CYCLES (H),
        .STAGE_GAP   (G),
        .CNT_W       (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks;
    int         errors;
    int         edge_n;
    int         origin;
    bit         core_ok;
    logic [1:0] m_cause;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at edge %0d", tag, obs, exp, edge_n);
        end
    endtask

    task automatic check_outputs();
        logic eb, ec;
        eb = ((edge_n - origin) >= H);
        ec = core_ok;
        chk("bus_rst_n",  {1'b0, sif.bus_rst_n},  {1'b0, eb});
        chk("core_rst_n", {1'b0, sif.core_rst_n}, {1'b0, ec});
        chk("rst_busy",   {1'b0, sif.rst_busy},   {1'b0, ~ec});
        chk("rst_cause",  sif.rst_cause,          m_cause);
    endtask

    // Drive one cycle of inputs, advance one edge, update the model, check.
    task automatic step(input logic sw, input logic wdt, input logic clr, input logic dbg);
        sif.sw_rst_req    = sw;
        sif.wdt_rst_req   = wdt;
        sif.rst_cause_clr = clr;
`ifdef RST_SEQ_DBG_HOLD_EN
        sif.dbg_core_hold = dbg;
`endif
        @(posedge clk);
        edge_n++;
        if (sw || wdt) begin
            origin  = edge_n;
            core_ok = 1'b0;
            m_cause = wdt ? 2'd2 : 2'd1;
        end else if (clr) begin
            m_cause = 2'd0;
        end
        if ((edge_n - origin) >= H + G && !dbg)
            core_ok = 1'b1;
        #1;
        check_outputs();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n   = 1'b1;
        origin  = edge_n;
        core_ok = 1'b0;
        m_cause = 2'd0;
    endtask

    initial begin
        bit   dbg_r;
        int   wdt_left;
        logic sw_r, wdt_r, clr_r;

        checks   = 0;
        errors   = 0;
        edge_n   = 0;
        origin   = 0;
        core_ok  = 1'b0;
        m_cause  = 2'd0;
        rst_n    = 1'b0;
        sif.sw_rst_req    = 1'b0;
        sif.wdt_rst_req   = 1'b0;
        sif.rst_cause_clr = 1'b0;
`ifdef RST_SEQ_DBG_HOLD_EN
        sif.dbg_core_hold = 1'b0;
`endif

        // Reset state while rst_n is held low
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bus",   {1'b0, sif.bus_rst_n},  2'd0);
        chk("rst_core",  {1'b0, sif.core_rst_n}, 2'd0);
        chk("rst_busy0", {1'b0, sif.rst_busy},   2'd1);
        chk("rst_cause0", sif.rst_cause,         2'd0);

        // Power-on sequence: bus at edge 16, core at edge 20
        release_reset();
        repeat (24) step(0, 0, 0, 0);

        // Software reset from RUN
        step(1, 0, 0, 0);
        repeat (22) step(0, 0, 0, 0);

        // Simultaneous requests: watchdog wins
        step(1, 1, 0, 0);
        repeat (22) step(0, 0, 0, 0);

        // Watchdog level held for 10 cycles
        repeat (10) step(0, 1, 0, 0);
        repeat (22) step(0, 0, 0, 0);

        // Restart during BUS_REL at cnt=2
        step(1, 0, 0, 0);
        repeat (H + 2) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (22) step(0, 0, 0, 0);

        // Restart during HOLD at cnt=10
        step(1, 0, 0, 0);
        repeat (10) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (22) step(0, 0, 0, 0);

        // Cause clear alone, then clear together with a request
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(1, 0, 1, 0);
        repeat (22) step(0, 0, 0, 0);

        // Asynchronous rst_n assertion in BUS_REL, no clock edge
        step(0, 1, 0, 0);
        repeat (H + 1) step(0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_bus",   {1'b0, sif.bus_rst_n},  2'd0);
        chk("async_core",  {1'b0, sif.core_rst_n}, 2'd0);
        chk("async_busy",  {1'b0, sif.rst_busy},   2'd1);
        chk("async_cause", sif.rst_cause,          2'd0);
        release_reset();
        repeat (22) step(0, 0, 0, 0);

`ifdef RST_SEQ_DBG_HOLD_EN
        // Debug hold through power-on; drop after edge 40, core at edge 41
        rst_n = 1'b0;
        #1;
        release_reset();
        repeat (40) step(0, 0, 0, 1);
        repeat (6) step(0, 0, 0, 0);
`endif

        // Randomized phase
        dbg_r    = 1'b0;
        wdt_left = 0;
        for (int i = 0; i < 1500; i++) begin
            sw_r  = ($urandom_range(0, 39) == 0);
            clr_r = ($urandom_range(0, 15) == 0);
            if (wdt_left == 0 && $urandom_range(0, 59) == 0)
                wdt_left = $urandom_range(1, 12);
            wdt_r = (wdt_left > 0);
            if (wdt_left > 0) wdt_left--;
`ifdef RST_SEQ_DBG_HOLD_EN
            if ($urandom_range(0, 19) == 0) dbg_r = ~dbg_r;
`endif
            step(sw_r, wdt_r, clr_r, dbg_r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- SoC reset generator and sequencer. It produces reset for downstream domains, which then pass through the per-domain reset synchronizers.
- Takes the already-synchronized system reset plus software and watchdog reset requests.
- Stretches each reset event to a fixed hold time, then releases the bus/peripheral domain before the core domain.
- Records the cause of the last reset for a status register.

Parameters:
- HOLD_CYCLES, 16: cycles both domains stay in reset after the reset source ends. Range 1..2**CNT_W-1.
- STAGE_GAP, 4: cycles between bus release and core release. Range 1..2**CNT_W-1.
- CNT_W, 8: width of the shared sequencing counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset, power-on/system.
- sw_rst_req  input  1  software reset request. Single-cycle pulse from a register write.
- wdt_rst_req  input  1  watchdog reset request. Level or pulse; sampled every cycle.
- rst_cause_clr  input  1  clears the cause register.
- bus_rst_n  output  1  active-low reset for the bus/peripheral domain.
- core_rst_n  output  1  active-low reset for the core domain.
- rst_busy  output  1  high while the sequence is not in RUN.
- rst_cause  output  2  last reset cause: 2'd0 POR, 2'd1 SW, 2'd2 WDT; 2'd3 is unused.

Behaviour:
- Reset scheme (already decided): one clock, clk. Reset rst_n is asynchronous and active-low.
- While rst_n=0: state=HOLD, cnt=0, bus_rst_n=0, core_rst_n=0, rst_busy=1, rst_cause=POR. All outputs are registered.
- FSM states are HOLD, BUS_REL, RUN.
- HOLD:
  - Both outputs are low.
  - cnt increments each cycle.
  - When cnt==HOLD_CYCLES-1: cnt←0, bus_rst_n←1, go to BUS_REL.
- Latency: bus_rst_n rises on the HOLD_CYCLES-th rising edge after the rst_n deassertion (or after the last request cycle).
- BUS_REL:
  - bus_rst_n=1, core_rst_n=0, cnt increments.
  - When cnt==STAGE_GAP-1: cnt←0, core_rst_n←1, rst_busy←0, go to RUN.
  - core_rst_n therefore rises STAGE_GAP edges after bus_rst_n.
- RUN: both outputs high, rst_busy=0.
- Request in any state (sw_rst_req or wdt_rst_req high at an edge):
  - Next state is HOLD, cnt←0, bus_rst_n←0, core_rst_n←0, rst_busy←1.
  - Outputs go low on the same edge that samples the request (one-cycle latency).
  - Requests in HOLD or BUS_REL restart the hold count from 0.
- A held-high wdt_rst_req keeps the block in HOLD. The hold count starts once the request drops.
- Cause update on any accepted request:
  - wdt_rst_req has priority over sw_rst_req when both are high in the same cycle, giving cause=WDT.
  - Otherwise cause=SW.
- rst_cause_clr sets rst_cause to 2'd0. If a request occurs in the same cycle, the request wins.
- rst_cause is not cleared by software/watchdog sequences. Only rst_n or rst_cause_clr reset it.
- rst_n asserted mid-sequence immediately forces all outputs to their reset values, asynchronously.
- Outputs are glitch-free: each is driven straight from a flop, with no combinational logic after it.

Optional Feature:
- Macro: RST_SEQ_DBG_HOLD_EN.
- Defined:
  - Adds input port dbg_core_hold (1 bit).
  - In BUS_REL, while dbg_core_hold=1 at the terminal count, the FSM stays in BUS_REL with cnt held at STAGE_GAP-1, bus_rst_n=1, core_rst_n=0. This lets a debugger attach before the core leaves reset.
  - Core release follows on the first edge with dbg_core_hold=0.
  - dbg_core_hold has no effect in RUN or HOLD.
- Undefined: the port is absent and the behaviour is as above.

Decomposition:
- Shared package/header holds:
  - FSM state encodings: HOLD=2'd0, BUS_REL=2'd1, RUN=2'd2.
  - Cause codes: RST_CAUSE_POR=2'd0, RST_CAUSE_SW=2'd1, RST_CAUSE_WDT=2'd2.
- No sub-module: a single flat block with FSM, counter and cause register.
- bus_rst_n and core_rst_n feed existing per-domain reset synchronizers at the integration level, not inside this block.

Test Plan (defaults HOLD_CYCLES=16, STAGE_GAP=4):
- Power-on: deassert rst_n → bus_rst_n rises at edge 16, core_rst_n at edge 20, rst_busy falls at edge 20, rst_cause=0.
- SW reset: in RUN, pulse sw_rst_req for 1 cycle → both outputs low at next edge, rst_cause=1, bus release 16 edges after the pulse edge, core 4 edges later.
- Simultaneous requests: sw_rst_req and wdt_rst_req high in the same cycle → rst_cause=2. A wdt level held for 10 cycles delays bus release to 16 edges after it drops.
- Restart mid-sequence: sw_rst_req pulse during BUS_REL (cnt=2) → bus_rst_n drops next edge and the full 16+4 sequence reruns. Likewise for a pulse in HOLD at cnt=10.
- Clear vs request: rst_cause_clr alone → rst_cause=0. rst_cause_clr with sw_rst_req in the same cycle → rst_cause=1. Async rst_n assertion in BUS_REL → outputs 0 without a clock edge.
- RST_SEQ_DBG_HOLD_EN defined: dbg_core_hold=1 during power-on → bus releases at edge 16 and core stays low. Drop the hold at edge 40 → core_rst_n high at edge 41.
